// File: rtl/reg_file.sv
// Dual-read, single-write register file with byte strobes, per-entry valid bits and clear-all.
// Define REG_FILE_BYPASS_EN to forward a same-cycle write into a same-address read.
module reg_file #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 32,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic [WIDTH/8-1:0]   wr_strb,
    input  logic                 rd_en_a,
    input  logic [AW-1:0]        rd_addr_a,
    input  logic                 rd_en_b,
    input  logic [AW-1:0]        rd_addr_b,
    output logic [WIDTH-1:0]     rd_data_a,
    output logic                 rd_valid_a,
    output logic [WIDTH-1:0]     rd_data_b,
    output logic                 rd_valid_b
);

    localparam logic [AW:0] LIMIT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] vld;

    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] merged;
    logic             wrInRange;
    logic             rdInRangeA;
    logic             rdInRangeB;
    logic             wrHit;
    logic [WIDTH-1:0] wordA;
    logic [WIDTH-1:0] wordB;
    logic             vldA;
    logic             vldB;

    assign wrInRange  = {1'b0, wr_addr}   < LIMIT;
    assign rdInRangeA = {1'b0, rd_addr_a} < LIMIT;
    assign rdInRangeB = {1'b0, rd_addr_b} < LIMIT;

    // A write only takes effect when in range, at least one byte is strobed and no clear is pending.
    assign wrHit = wr_en && (wr_strb != '0) && wrInRange && !clear;

    // Expand byte strobes into a bit mask and merge new bytes over the current entry.
    always_comb begin
        mask = '0;
        for (int i = 0; i < WIDTH/8; i++) begin
            mask[8*i +: 8] = {8{wr_strb[i]}};
        end
        merged = (mem[wr_addr] & ~mask) | (wr_data & mask);
    end

    // Read-side selection; out-of-range indices return an unwritten, zero entry.
    always_comb begin
        wordA = mem[rd_addr_a];
        vldA  = vld[rd_addr_a];
        wordB = mem[rd_addr_b];
        vldB  = vld[rd_addr_b];
`ifdef REG_FILE_BYPASS_EN
        if (wrHit && (rd_addr_a == wr_addr)) begin
            wordA = merged;
            vldA  = 1'b1;
        end
        if (wrHit && (rd_addr_b == wr_addr)) begin
            wordB = merged;
            vldB  = 1'b1;
        end
`endif
        if (!rdInRangeA) begin
            wordA = '0;
            vldA  = 1'b0;
        end
        if (!rdInRangeB) begin
            wordB = '0;
            vldB  = 1'b0;
        end
    end

    // Storage and registered read ports; reads sample contents before any same-edge clear or write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            vld        <= '0;
            rd_data_a  <= '0;
            rd_valid_a <= 1'b0;
            rd_data_b  <= '0;
            rd_valid_b <= 1'b0;
        end else begin
            if (rd_en_a) begin
                rd_data_a  <= wordA;
                rd_valid_a <= vldA;
            end
            if (rd_en_b) begin
                rd_data_b  <= wordB;
                rd_valid_b <= vldB;
            end
            if (clear) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem[i] <= '0;
                end
                vld <= '0;
            end else if (wrHit) begin
                mem[wr_addr] <= merged;
                vld[wr_addr] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file (WIDTH=64, DEPTH=20): stimulus pushes expected read results,
// a negedge monitor pops them one cycle after each read and also checks that outputs hold.
module tb_reg_file;

    localparam int WIDTH = 64;
    localparam int DEPTH = 20;
    localparam int AW    = 5;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             valid;
        string            name;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset, clear, wr_en, rd_en_a, rd_en_b;
    logic [AW-1:0]    wr_addr, rd_addr_a, rd_addr_b;
    logic [WIDTH-1:0] wr_data;
    logic [7:0]       wr_strb;
    logic [WIDTH-1:0] rd_data_a, rd_data_b;
    logic             rd_valid_a, rd_valid_b;

    exp_t qA[$];
    exp_t qB[$];
    exp_t lastA, lastB;
    int   checks = 0;
    int   errors = 0;

    logic started = 1'b0;
    logic pendA = 1'b0, pendB = 1'b0, wasRst = 1'b0;

    reg_file #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
        .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a),
        .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_valid_a(rd_valid_a),
        .rd_data_b(rd_data_b), .rd_valid_b(rd_valid_b)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] act, input logic actV,
                               input logic [WIDTH-1:0] exp, input logic expV);
        checks++;
        if (act !== exp || actV !== expV) begin
            errors++;
            $display("[TB] FAIL %s: got data=%h valid=%b, want data=%h valid=%b",
                     name, act, actV, exp, expV);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic clr, input logic we,
                                 input logic [AW-1:0] wa, input logic [WIDTH-1:0] wd,
                                 input logic [7:0] ws,
                                 input logic rea, input logic [AW-1:0] raa,
                                 input logic reb, input logic [AW-1:0] rab);
        reset = rst; clear = clr; wr_en = we; wr_addr = wa; wr_data = wd; wr_strb = ws;
        rd_en_a = rea; rd_addr_a = raa; rd_en_b = reb; rd_addr_b = rab;
        @(posedge clk);
        #1;
    endtask

    task automatic expectA(input logic [WIDTH-1:0] d, input logic v, input string n);
        exp_t e;
        e.data = d; e.valid = v; e.name = n;
        qA.push_back(e);
    endtask

    task automatic expectB(input logic [WIDTH-1:0] d, input logic v, input string n);
        exp_t e;
        e.data = d; e.valid = v; e.name = n;
        qB.push_back(e);
    endtask

    task automatic writeEntry(input logic [AW-1:0] a, input logic [WIDTH-1:0] d, input logic [7:0] s);
        applyStimulus(0, 0, 1, a, d, s, 0, '0, 0, '0);
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, '0, '0, '0, 0, '0, 0, '0);
    endtask

    always @(posedge clk) begin
        pendA  <= rd_en_a && !reset;
        pendB  <= rd_en_b && !reset;
        wasRst <= reset;
        if (reset) started <= 1'b1;
    end

    // Monitor: one cycle after a read pops the scoreboard, otherwise outputs must hold.
    always @(negedge clk) begin
        if (started) begin
            if (wasRst) begin
                lastA.data = '0; lastA.valid = 1'b0; lastA.name = "reset_a";
                lastB.data = '0; lastB.valid = 1'b0; lastB.name = "reset_b";
                checkOutput("reset_a", rd_data_a, rd_valid_a, '0, 1'b0);
                checkOutput("reset_b", rd_data_b, rd_valid_b, '0, 1'b0);
            end else begin
                if (pendA) begin
                    if (qA.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL scoreboard_a: read result with no expectation queued");
                    end else begin
                        lastA = qA.pop_front();
                        checkOutput(lastA.name, rd_data_a, rd_valid_a, lastA.data, lastA.valid);
                    end
                end else begin
                    checkOutput("hold_a", rd_data_a, rd_valid_a, lastA.data, lastA.valid);
                end
                if (pendB) begin
                    if (qB.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL scoreboard_b: read result with no expectation queued");
                    end else begin
                        lastB = qB.pop_front();
                        checkOutput(lastB.name, rd_data_b, rd_valid_b, lastB.data, lastB.valid);
                    end
                end else begin
                    checkOutput("hold_b", rd_data_b, rd_valid_b, lastB.data, lastB.valid);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; clear = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = '0;
        rd_en_a = 1'b0; rd_addr_a = '0; rd_en_b = 1'b0; rd_addr_b = '0;
        @(posedge clk);
        #1;
        applyStimulus(1, 0, 0, '0, '0, '0, 0, '0, 0, '0);

        // Reset wipes a written entry; requests in the reset cycle are discarded.
        writeEntry(3, 64'h1122334455667788, 8'hFF);
        expectA(64'h1122334455667788, 1, "write_then_read_3");
        applyStimulus(0, 0, 0, '0, '0, '0, 1, 3, 0, '0);
        applyStimulus(1, 0, 1, 4, 64'h99, 8'hFF, 1, 3, 1, 3);
        expectA(64'h0, 0, "after_reset_read_3");
        expectB(64'h0, 0, "after_reset_read_4");
        applyStimulus(0, 0, 0, '0, '0, '0, 1, 3, 1, 4);

        // Byte strobes: only the low four bytes are cleared.
        writeEntry(5, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
        writeEntry(5, 64'h0, 8'h0F);
        expectA(64'hFFFFFFFF00000000, 1, "strobe_merge_5");
        applyStimulus(0, 0, 0, '0, '0, '0, 1, 5, 0, '0);

        // All-zero strobe is a no-op: entry 6 stays unwritten.
        writeEntry(6, 64'h1234, 8'h00);
        expectB(64'h0, 0, "zero_strobe_6");
        applyStimulus(0, 0, 0, '0, '0, '0, 0, '0, 1, 6);

        // Same-cycle read/write of entry 7.
        writeEntry(7, 64'hA, 8'hFF);
`ifdef REG_FILE_BYPASS_EN
        expectA(64'hB, 1, "same_cycle_rw_7");
`else
        expectA(64'hA, 1, "same_cycle_rw_7");
`endif
        applyStimulus(0, 0, 1, 7, 64'hB, 8'hFF, 1, 7, 0, '0);
        expectA(64'hB, 1, "after_rw_7");
        expectB(64'hB, 1, "zero_strobe_no_bypass_7");
        applyStimulus(0, 0, 1, 7, 64'hC, 8'h00, 1, 7, 1, 7);

        // Out-of-range indices: writes ignored, reads return zero.
        writeEntry(25, 64'hDEAD, 8'hFF);
        writeEntry(20, 64'hBEEF, 8'hFF);
        expectA(64'h0, 0, "oob_read_25");
        expectB(64'h0, 0, "oob_read_20");
        applyStimulus(0, 0, 0, '0, '0, '0, 1, 25, 1, 20);
        writeEntry(19, 64'h1919, 8'hFF);
        expectA(64'h1919, 1, "last_entry_19");
        expectB(64'hFFFFFFFF00000000, 1, "untouched_5");
        applyStimulus(0, 0, 0, '0, '0, '0, 1, 19, 1, 5);
        expectA(64'h0, 0, "untouched_9");
        expectB(64'h0, 0, "untouched_0");
        applyStimulus(0, 0, 0, '0, '0, '0, 1, 9, 1, 0);

        // Dual-port read of one entry, then outputs hold while both enables are low.
        writeEntry(1, 64'h55AA, 8'hFF);
        expectA(64'h55AA, 1, "dual_read_a_1");
        expectB(64'h55AA, 1, "dual_read_b_1");
        applyStimulus(0, 0, 0, '0, '0, '0, 1, 1, 1, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 1, 1, 64'h7777 + i, 8'hFF, 0, 3, 0, 5);
        end

        // Fill every entry, then clear with a simultaneous write and reads of pre-clear data.
        for (int i = 0; i < DEPTH; i++) begin
            writeEntry(AW'(i), 64'(100 + i), 8'hFF);
        end
        expectA(64'd104, 1, "pre_clear_read_4");
        expectB(64'd102, 1, "pre_clear_read_2");
        applyStimulus(0, 1, 1, 2, 64'hFACE, 8'hFF, 1, 4, 1, 2);
        for (int i = 0; i < DEPTH; i++) begin
            expectA(64'h0, 0, $sformatf("cleared_a_%0d", i));
            expectB(64'h0, 0, $sformatf("cleared_b_%0d", i));
            applyStimulus(0, 0, 0, '0, '0, '0, 1, AW'(i), 1, AW'(DEPTH - 1 - i));
        end

        idle();
        idle();
        checks++;
        if (qA.size() != 0 || qB.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d/%0d pending, want 0/0", qA.size(), qB.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
